hazard_scoreboard: RTL and testbench

- Pipeline interlock controller for the ID stage of the static pipeline.
- Tracks destination registers of in-flight instructions in a shift-register scoreboard, and tracks the HI/LO multi-cycle unit with a busy counter.
- Raises a stall when the instruction in ID reads a pending GPR, reads HI/LO (mfhi/mflo) while a mult/div is outstanding, or issues mult/div while one is outstanding.
- Replaces per-stage countdown stall logic with a single registered controller that also reports stall statistics.

---
 rtl/hazard_scoreboard.sv | 165 ++++++++++++++++
 tb/tb_hazard_scoreboard.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard
// Description : ID-stage interlock controller for the static pipeline.
//               In-flight GPR destinations are held in a DEPTH-deep shift
//               register. The HI/LO mult/div unit is tracked by a busy
//               down-counter. A stall is raised when the ID instruction
//               reads a pending GPR, or touches HI/LO while a mult/div result
//               is outstanding. A saturating counter records stalled cycles.
//
// Ports
//   clk           : clock, rising edge
//   reset         : asynchronous, active-high; clears all state
//   id_valid      : ID stage holds a real instruction (0 = bubble)
//   id_rs_addr    : rs field of the ID instruction
//   id_rt_addr    : rt field of the ID instruction
//   id_rs_used    : ID instruction reads rs
//   id_rt_used    : ID instruction reads rt
//   id_dst_addr   : GPR destination selected by decode
//   id_dst_we     : ID instruction writes a GPR
//   id_is_muldiv  : ID instruction writes HI/LO through the mult/div unit
//   id_is_mfhilo  : ID instruction is mfhi/mflo
//   id_flush      : ID instruction is squashed this cycle
//   stall         : hold PC/IF/ID and insert a bubble into EXE
//   issue         : ID instruction advances this cycle
//   hazard_rs     : rs operand hazard active
//   hazard_rt     : rt operand hazard active
//   muldiv_busy   : HI/LO result outstanding
//   stall_cycles  : saturating count of cycles with stall=1
//
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard #(
    parameter int DEPTH      = 3,
    parameter int MULDIV_LAT = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_rs_addr,
    input  logic [4:0]       id_rt_addr,
    input  logic             id_rs_used,
    input  logic             id_rt_used,
    input  logic [4:0]       id_dst_addr,
    input  logic             id_dst_we,
    input  logic             id_is_muldiv,
    input  logic             id_is_mfhilo,
    input  logic             id_flush,
    output logic             stall,
    output logic             issue,
    output logic             hazard_rs,
    output logic             hazard_rt,
    output logic             muldiv_busy,
    output logic [CNT_W-1:0] stall_cycles
);

    // Busy counter must be able to hold MULDIV_LAT itself.
    localparam int                c_busy_w    = (MULDIV_LAT < 1) ? 1 : $clog2(MULDIV_LAT + 1);
    localparam logic [c_busy_w-1:0] c_busy_load = c_busy_w'(MULDIV_LAT);
    localparam logic [c_busy_w-1:0] c_busy_one  = c_busy_w'(1);
    localparam logic [CNT_W-1:0]    c_cnt_one   = CNT_W'(1);
    localparam logic [CNT_W-1:0]    c_cnt_max   = {CNT_W{1'b1}};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DEPTH-1:0]    r_slot_valid;
    logic [4:0]          r_slot_addr [DEPTH];
    logic [c_busy_w-1:0] r_busy_cnt;
    logic [CNT_W-1:0]    r_stall_cycles;

    // ------------------------------------------------------------------
    // Per-slot address comparison
    // ------------------------------------------------------------------
    logic [DEPTH-1:0] w_rs_match;
    logic [DEPTH-1:0] w_rt_match;

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_match
            assign w_rs_match[i] = r_slot_valid[i] && (r_slot_addr[i] == id_rs_addr);
            assign w_rt_match[i] = r_slot_valid[i] && (r_slot_addr[i] == id_rt_addr);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Hazard and issue terms
    // ------------------------------------------------------------------
    logic w_hazard_rs;
    logic w_hazard_rt;
    logic w_muldiv_busy;
    logic w_hilo_hz;
    logic w_stall;
    logic w_issue;
    logic w_record_dst;

    // $0 is hardwired to zero, so reading it can never depend on a producer.
    assign w_hazard_rs   = id_valid && id_rs_used && (id_rs_addr != 5'd0) && (|w_rs_match);
    assign w_hazard_rt   = id_valid && id_rt_used && (id_rt_addr != 5'd0) && (|w_rt_match);
    assign w_muldiv_busy = (r_busy_cnt != '0);
    // A second mult/div is held off too, so the busy counter never reloads
    // while a result is still outstanding.
    assign w_hilo_hz     = id_valid && (id_is_mfhilo || id_is_muldiv) && w_muldiv_busy;
    // A squashed instruction never waits for its operands.
    assign w_stall       = (w_hazard_rs || w_hazard_rt || w_hilo_hz) && !id_flush;
    assign w_issue       = id_valid && !w_stall && !id_flush;
    assign w_record_dst  = w_issue && id_dst_we && (id_dst_addr != 5'd0);

    // ------------------------------------------------------------------
    // Scoreboard shift register. Shifting continues while stalled so that
    // older producers always drain; the stalled/flushed/empty slot enters
    // as a bubble.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_slot_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_slot_addr[i] <= 5'd0;
            end
        end else begin
            r_slot_valid[0] <= w_record_dst;
            r_slot_addr[0]  <= w_record_dst ? id_dst_addr : 5'd0;
            for (int i = 1; i < DEPTH; i++) begin
                r_slot_valid[i] <= r_slot_valid[i-1];
                r_slot_addr[i]  <= r_slot_addr[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // HI/LO busy counter: load on mult/div issue, otherwise count down.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy_cnt <= '0;
        end else if (w_issue && id_is_muldiv) begin
            r_busy_cnt <= c_busy_load;
        end else if (w_muldiv_busy) begin
            r_busy_cnt <= r_busy_cnt - c_busy_one;
        end
    end

    // ------------------------------------------------------------------
    // Saturating stall statistics
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cycles <= '0;
        end else if (w_stall && (r_stall_cycles != c_cnt_max)) begin
            r_stall_cycles <= r_stall_cycles + c_cnt_one;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign stall        = w_stall;
    assign issue        = w_issue;
    assign hazard_rs    = w_hazard_rs;
    assign hazard_rt    = w_hazard_rt;
    assign muldiv_busy  = w_muldiv_busy;
    assign stall_cycles = r_stall_cycles;

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_scoreboard
// Description : Self-checking bench for hazard_scoreboard. A per-cycle vector
//               table (inputs plus hand-derived expected outputs) is applied
//               through an expectation queue; hand-written sequences cover
//               reset during a stall and stall-counter saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs_addr;
    logic [4:0]  id_rt_addr;
    logic        id_rs_used;
    logic        id_rt_used;
    logic [4:0]  id_dst_addr;
    logic        id_dst_we;
    logic        id_is_muldiv;
    logic        id_is_mfhilo;
    logic        id_flush;

    logic        stall, issue, hazard_rs, hazard_rt, muldiv_busy;
    logic [15:0] stall_cycles;
    logic        s_stall, s_issue, s_hazard_rs, s_hazard_rt, s_muldiv_busy;
    logic [3:0]  s_stall_cycles;

    hazard_scoreboard #(.DEPTH(3), .MULDIV_LAT(4), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .id_dst_addr(id_dst_addr), .id_dst_we(id_dst_we),
        .id_is_muldiv(id_is_muldiv), .id_is_mfhilo(id_is_mfhilo),
        .id_flush(id_flush), .stall(stall), .issue(issue),
        .hazard_rs(hazard_rs), .hazard_rt(hazard_rt),
        .muldiv_busy(muldiv_busy), .stall_cycles(stall_cycles)
    );

    // Narrow-counter instance for the saturation check; shares all inputs.
    hazard_scoreboard #(.DEPTH(3), .MULDIV_LAT(4), .CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .id_dst_addr(id_dst_addr), .id_dst_we(id_dst_we),
        .id_is_muldiv(id_is_muldiv), .id_is_mfhilo(id_is_mfhilo),
        .id_flush(id_flush), .stall(s_stall), .issue(s_issue),
        .hazard_rs(s_hazard_rs), .hazard_rt(s_hazard_rt),
        .muldiv_busy(s_muldiv_busy), .stall_cycles(s_stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       rsu;
        logic       rtu;
        logic [4:0] dst;
        logic       we;
        logic       md;
        logic       mf;
        logic       fl;
        logic       e_stall;
        logic       e_issue;
        logic       e_hrs;
        logic       e_hrt;
        logic       e_busy;
    } vec_t;

    typedef struct {
        logic stall;
        logic issue;
        logic hrs;
        logic hrt;
        logic busy;
        int   cnt;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    function automatic vec_t mk(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                                input logic rsu, input logic rtu, input logic [4:0] dst,
                                input logic we, input logic md, input logic mf, input logic fl,
                                input logic e_stall, input logic e_issue, input logic e_hrs,
                                input logic e_hrt, input logic e_busy);
        vec_t r;
        r.v = v; r.rs = rs; r.rt = rt; r.rsu = rsu; r.rtu = rtu; r.dst = dst;
        r.we = we; r.md = md; r.mf = mf; r.fl = fl;
        r.e_stall = e_stall; r.e_issue = e_issue; r.e_hrs = e_hrs;
        r.e_hrt = e_hrt; r.e_busy = e_busy;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t x);
        id_valid     = x.v;
        id_rs_addr   = x.rs;
        id_rt_addr   = x.rt;
        id_rs_used   = x.rsu;
        id_rt_used   = x.rtu;
        id_dst_addr  = x.dst;
        id_dst_we    = x.we;
        id_is_muldiv = x.md;
        id_is_mfhilo = x.mf;
        id_flush     = x.fl;
    endtask

    task automatic idle();
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int   exp_cnt;
        int   sat_cnt;
        exp_t e;

        // ---- Vector table: one row per cycle, expected outputs derived by hand.
        // Back-to-back RAW on $5: three stall cycles, then issue.
        vecs.push_back(mk(1, 0, 0, 0, 0, 5, 1, 0, 0, 0,   0, 1, 0, 0, 0));
        repeat (3) vecs.push_back(mk(1, 5, 0, 1, 0, 0, 0, 0, 0, 0,   1, 0, 1, 0, 0));
        vecs.push_back(mk(1, 5, 0, 1, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0));
        // Producer $7, one independent instruction, consumer on rt: two stalls.
        vecs.push_back(mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0,   0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0));
        repeat (2) vecs.push_back(mk(1, 0, 7, 0, 1, 0, 0, 0, 0, 0,   1, 0, 0, 1, 0));
        vecs.push_back(mk(1, 0, 7, 0, 1, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0));
        // $0 producer is never recorded; $0 reads never hazard.
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0,   0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 1, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0));
        // Invalid ID never hazards, but the older producer still drains.
        vecs.push_back(mk(1, 0, 0, 0, 0, 6, 1, 0, 0, 0,   0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 6, 0, 1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0));
        repeat (2) vecs.push_back(mk(1, 6, 0, 1, 0, 0, 0, 0, 0, 0,   1, 0, 1, 0, 0));
        vecs.push_back(mk(1, 6, 0, 1, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0));
        // Flush during a hazard: no stall, no issue; the follower stalls twice.
        vecs.push_back(mk(1, 0, 0, 0, 0, 9, 1, 0, 0, 0,   0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 9, 0, 1, 0, 0, 0, 0, 0, 1,   0, 0, 1, 0, 0));
        repeat (2) vecs.push_back(mk(1, 9, 0, 1, 0, 0, 0, 0, 0, 0,   1, 0, 1, 0, 0));
        vecs.push_back(mk(1, 9, 0, 1, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0));
        // mult then mflo: four busy/stall cycles.
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0,   0, 1, 0, 0, 0));
        repeat (4) vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0,   1, 0, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0,   0, 1, 0, 0, 0));
        // mult then mult: second one waits four cycles, then reloads.
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0,   0, 1, 0, 0, 0));
        repeat (4) vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0,   1, 0, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0,   0, 1, 0, 0, 0));
        repeat (4) vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1));
        // mul writing $4 and HI/LO; consumer reads $4 twice and is mflo.
        vecs.push_back(mk(1, 0, 0, 0, 0, 4, 1, 1, 0, 0,   0, 1, 0, 0, 0));
        repeat (3) vecs.push_back(mk(1, 4, 4, 1, 1, 0, 0, 0, 1, 0,   1, 0, 1, 1, 1));
        vecs.push_back(mk(1, 4, 4, 1, 1, 0, 0, 0, 1, 0,   1, 0, 0, 0, 1));
        vecs.push_back(mk(1, 4, 4, 1, 1, 0, 0, 0, 1, 0,   0, 1, 0, 0, 0));

        // ---- Reset state
        idle();
        reset = 1'b1;
        #1;
        check("reset stall", 32'(stall), 0);
        check("reset issue", 32'(issue), 0);
        check("reset hazard_rs", 32'(hazard_rs), 0);
        check("reset hazard_rt", 32'(hazard_rt), 0);
        check("reset muldiv_busy", 32'(muldiv_busy), 0);
        check("reset stall_cycles", 32'(stall_cycles), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // ---- Table run through the expectation queue
        exp_cnt = 0;
        for (int k = 0; k < vecs.size(); k++) begin
            @(negedge clk);
            apply(vecs[k]);
            e.stall = vecs[k].e_stall;
            e.issue = vecs[k].e_issue;
            e.hrs   = vecs[k].e_hrs;
            e.hrt   = vecs[k].e_hrt;
            e.busy  = vecs[k].e_busy;
            e.cnt   = exp_cnt;
            exp_q.push_back(e);
            exp_cnt += int'(vecs[k].e_stall);
            #2;
            e = exp_q.pop_front();
            check($sformatf("row%0d stall", k), 32'(stall), 32'(e.stall));
            check($sformatf("row%0d issue", k), 32'(issue), 32'(e.issue));
            check($sformatf("row%0d hazard_rs", k), 32'(hazard_rs), 32'(e.hrs));
            check($sformatf("row%0d hazard_rt", k), 32'(hazard_rt), 32'(e.hrt));
            check($sformatf("row%0d muldiv_busy", k), 32'(muldiv_busy), 32'(e.busy));
            check($sformatf("row%0d stall_cycles", k), 32'(stall_cycles), 32'(e.cnt));
            check($sformatf("row%0d sat stall", k), 32'(s_stall), 32'(e.stall));
        end
        @(negedge clk);
        idle();
        #2;
        check("table total stall_cycles", 32'(stall_cycles), 32'(exp_cnt));

        // ---- Reset asserted mid-stall
        do_reset();
        @(negedge clk);
        apply(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 0));   // mult
        @(negedge clk);
        apply(mk(1, 0, 0, 0, 0, 3, 1, 0, 0, 0,   0, 0, 0, 0, 0));   // add $3
        #2;
        check("midrst producer issue", 32'(issue), 1);
        @(negedge clk);
        apply(mk(1, 3, 0, 1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0));   // reads $3
        #2;
        check("midrst consumer stall", 32'(stall), 1);
        check("midrst muldiv_busy", 32'(muldiv_busy), 1);
        @(negedge clk);
        #2;
        check("midrst stall_cycles before", 32'(stall_cycles), 1);
        reset = 1'b1;
        #1;
        check("midrst stall in reset", 32'(stall), 0);
        check("midrst hazard_rs in reset", 32'(hazard_rs), 0);
        check("midrst busy in reset", 32'(muldiv_busy), 0);
        check("midrst issue in reset", 32'(issue), 1);
        check("midrst count in reset", 32'(stall_cycles), 0);
        @(negedge clk);
        reset = 1'b0;
        #2;
        check("midrst stall after", 32'(stall), 0);
        check("midrst issue after", 32'(issue), 1);
        check("midrst count after", 32'(stall_cycles), 0);

        // ---- Saturation: self-dependent $10 writer re-arms its own hazard
        do_reset();
        sat_cnt = 0;
        for (int k = 0; k < 28; k++) begin
            logic exp_st;
            @(negedge clk);
            apply(mk(1, 10, 0, 1, 0, 10, 1, 0, 0, 0,   0, 0, 0, 0, 0));
            exp_st = ((k % 4) != 0);
            #2;
            check($sformatf("sat cyc%0d stall", k), 32'(s_stall), 32'(exp_st));
            check($sformatf("sat cyc%0d count", k), 32'(s_stall_cycles),
                  32'((sat_cnt > 15) ? 15 : sat_cnt));
            sat_cnt += int'(exp_st);
        end
        @(negedge clk);
        idle();
        #2;
        check("sat wide count", 32'(stall_cycles), 21);
        check("sat narrow count", 32'(s_stall_cycles), 15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
